multisim_frame_splitter: RTL and testbench
==========================================

# multisim_frame_splitter

Sits directly downstream of the multisim server stage and consumes its `data_vld`/`data`/`data_rdy` word stream. Parses it into framed messages: a header word, then a payload of N words. Payload words pass through a small FIFO to the consumer with start/end-of-frame markers and the frame's channel ID. Header words are consumed internally and never forwarded.

## Interface
- `DATA_WIDTH`, 64, word width; must be >= 32
- `FIFO_DEPTH`, 4, payload FIFO entries; power of 2, >= 2
- `clk`  input  1  clock; all logic on rising edge
- `rst`  input  1  asynchronous, active-high reset
- `in_vld`  input  1  upstream word valid (server `data_vld`)
- `in_data`  input  DATA_WIDTH  upstream word (server `data`)
- `in_rdy`  output  1  upstream may advance (drives server `data_rdy`)
- `out_vld`  output  1  payload word available
- `out_rdy`  input  1  consumer accepts payload word
- `out_data`  output  DATA_WIDTH  payload word
- `out_sop`  output  1  first payload word of frame
- `out_eop`  output  1  last payload word of frame
- `out_chan`  output  16  channel ID of the current frame
- `err_zero_len`  output  1  one-cycle pulse when a zero-length header is dropped
- `frame_cnt`  output  32  count of frames fully delivered on the output

## Operation
- Transfer rule: an input word is accepted when `in_vld && in_rdy` at a rising edge. An output word is accepted when `out_vld && out_rdy`.
- The FSM has two states, HEADER and PAYLOAD. Reset state is HEADER.
- **HEADER**
  - `in_rdy` = 1.
  - On accept: latch `len` = `in_data[15:0]` and `chan` = `in_data[31:16]`. Bits above 31 are ignored.
  - If `len` == 0: pulse `err_zero_len` for 1 cycle and stay in HEADER. Nothing is written to the FIFO.
  - Otherwise: `remaining` <= `len`, set `first` <= 1, and go to PAYLOAD.
- **PAYLOAD**
  - `in_rdy` = !fifo_full.
  - On accept, push the entry {`in_data`, sop=`first`, eop=(`remaining`==1), `chan`}.
  - Then clear `first` and decrement `remaining`.
  - If eop was pushed, return to HEADER.
- **FIFO**
  - First-word-fall-through: `out_vld` = !empty, and `out_*` always reflect the head entry.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2·FIFO_DEPTH.
  - Full is (count == FIFO_DEPTH); empty is (count == 0).
- **`frame_cnt`**
  - Increments by 1 on each output accept with `out_eop` = 1.
  - Wraps from 0xFFFF_FFFF to 0.
- **Maximum frame length:** `len` is 16-bit, so frames of up to 65535 words are legal. `remaining` is 16 bits and must never underflow.

## Timing
- **Reset.** While `rst` is high, and asynchronously on its assertion:
  - state = HEADER; FIFO empty; `remaining`, `len`, `chan` and `first` cleared.
  - `out_vld`=0, `out_sop`=0, `out_eop`=0, `out_chan`=0, `out_data`=0, `err_zero_len`=0, `frame_cnt`=0, `in_rdy`=0.
- `in_rdy` rises in the first cycle after `rst` deasserts.
- Reset mid-frame discards the partial frame and all FIFO contents. No `eop` is emitted for it and `frame_cnt` is unchanged from 0.
- **Latency.** A payload word accepted at edge N drives `out_vld`=1 after edge N; the consumer can accept it at edge N+1.
- A header costs 1 input cycle with no output.
- **Back-to-back frames.**
  - The last payload word of frame A is accepted at edge N.
  - The header of frame B is accepted at edge N+1.
  - The first payload word of frame B is accepted at edge N+2.
- **Full FIFO.** `in_rdy`=0 even if a pop happens in the same cycle; there is no push-through when full. Throughput stays 1 word/cycle whenever FIFO_DEPTH >= 2 and the consumer is always ready.
- **Simultaneous push and pop** when not full and not empty: count is unchanged and both transfers occur.
- **Single-word frame** (`len`=1): the entry carries `out_sop`=1 and `out_eop`=1 together.
- **Combinational paths:**
  - `in_rdy` is a function of registered state and count only. It never depends on `in_vld` or `out_rdy`.
  - The `out_*` signals are registered FIFO outputs.

## Test plan
- **Reset.** Assert `rst` mid-cycle, then release.
  - During reset: all outputs are 0 immediately (asynchronous), including `in_rdy`=0.
  - After release: `in_rdy`=1 one cycle later.
- **Basic frame.** Header 0x0000_0000_0005_0003, then payload 0xA0, 0xA1, 0xA2, with `out_rdy`=1.
  - Output is 3 words with `out_chan`=5, sop on 0xA0 and eop on 0xA2.
  - `frame_cnt`=1.
  - Each word appears 1 cycle after its input accept.
- **Backpressure.** FIFO_DEPTH=4, header len=10, `out_rdy`=0.
  - `in_rdy` drops after the 4th payload word.
  - Then raise `out_rdy`: all 10 words arrive in order and `frame_cnt`=1.
- **Zero-length and single-word frames.**
  - Header len=0, chan=7: `err_zero_len` pulses for 1 cycle, there is no output, and the FSM stays in HEADER.
  - Next, header len=1 with word 0xBEEF: one output word with sop=eop=1.
- **Back-to-back frames with random `out_rdy`.** 50 frames, len 1–20, random `in_vld` gaps.
  - Output order, sop/eop and channel IDs match a scoreboard.
  - `frame_cnt`=50.
- **Counter wrap and mid-frame reset.**
  - Force `frame_cnt`=0xFFFF_FFFF, then complete 1 frame: `frame_cnt` reads 0.
  - Start a len=8 frame, assert `rst` after 3 words: FIFO is empty and the next header is parsed correctly.

Source files
------------

// File: rtl/multisim_frame_splitter.sv
// Splits the multisim server word stream into header-delimited frames and
// forwards payload words, tagged with sop/eop/channel, through a FWFT FIFO.
`timescale 1ns/1ps
module multisim_frame_splitter #(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_rdy,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [15:0]           out_chan,
  output logic                  err_zero_len,
  output logic [31:0]           frame_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_WIDTH + 18;

  typedef enum logic {HEADER, PAYLOAD} state_t;

  state_t          r_state;
  logic            r_active;
  logic [15:0]     r_remaining;
  logic [15:0]     r_chan;
  logic            r_first;
  logic            r_err_zero_len;
  logic [31:0]     r_frame_cnt;
  logic [AW:0]     r_wptr;
  logic [AW:0]     r_rptr;
  logic [EW-1:0]   r_mem [FIFO_DEPTH];

  logic [AW:0]     w_count;
  logic            w_full;
  logic            w_empty;
  logic            w_in_acc;
  logic            w_hdr_acc;
  logic            w_push;
  logic            w_pop;
  logic            w_last;
  logic [EW-1:0]   w_head;

  assign w_count   = r_wptr - r_rptr;
  assign w_full    = (w_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty   = (w_count == '0);
  // r_active holds in_rdy low through reset and for the edge that releases it
  assign in_rdy    = r_active && ((r_state == HEADER) || !w_full);
  assign w_in_acc  = in_vld && in_rdy;
  assign w_hdr_acc = w_in_acc && (r_state == HEADER);
  assign w_push    = w_in_acc && (r_state == PAYLOAD);
  assign w_pop     = !w_empty && out_rdy;
  assign w_last    = (r_remaining == 16'd1);
  assign w_head    = r_mem[r_rptr[AW-1:0]];

  // Head entry is masked while empty so stale storage never shows on the outputs
  assign out_vld = !w_empty;
  assign {out_data, out_sop, out_eop, out_chan} = w_empty ? '0 : w_head;
  assign err_zero_len = r_err_zero_len;
  assign frame_cnt    = r_frame_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= HEADER;
      r_active       <= 1'b0;
      r_remaining    <= '0;
      r_chan         <= '0;
      r_first        <= 1'b0;
      r_err_zero_len <= 1'b0;
      r_frame_cnt    <= '0;
      r_wptr         <= '0;
      r_rptr         <= '0;
    end else begin
      r_active       <= 1'b1;
      r_err_zero_len <= 1'b0;
      if (w_hdr_acc) begin
        r_remaining <= in_data[15:0];
        r_chan      <= in_data[31:16];
        if (in_data[15:0] == '0) begin
          r_err_zero_len <= 1'b1;
        end else begin
          r_first <= 1'b1;
          r_state <= PAYLOAD;
        end
      end
      if (w_push) begin
        r_first     <= 1'b0;
        r_remaining <= r_remaining - 16'd1;
        r_wptr      <= r_wptr + 1'b1;
        if (w_last) r_state <= HEADER;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        if (out_eop) r_frame_cnt <= r_frame_cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= {in_data, r_first, w_last, r_chan};
  end

endmodule

// File: tb/tb_multisim_frame_splitter.sv
// Directed plus randomized bench for multisim_frame_splitter; expected output
// entries come from a frame-level scoreboard built when frames are scheduled.
`timescale 1ns/1ps
module tb_multisim_frame_splitter;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [15:0] chan;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_vld = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_rdy;
  logic        out_vld;
  logic        out_rdy = 1'b0;
  logic [63:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic [15:0] out_chan;
  logic        err_zero_len;
  logic [31:0] frame_cnt;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned exp_frames = 0;
  logic [63:0] txq[$];
  exp_t        sb[$];

  always #5 clk = ~clk;

  multisim_frame_splitter #(.DATA_WIDTH(64), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_rdy(in_rdy),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_sop(out_sop),
    .out_eop(out_eop), .out_chan(out_chan), .err_zero_len(err_zero_len),
    .frame_cnt(frame_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, sample 1 ns later; the transfer happens at the next rising edge.
  task automatic step(input logic vld, input logic [63:0] d, input logic ordy, output logic acc);
    exp_t e;
    @(negedge clk);
    in_vld = vld;
    in_data = d;
    out_rdy = ordy;
    #1;
    acc = vld && in_rdy;
    if (out_vld && out_rdy) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 64'(out_vld), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_sop", 64'(out_sop), 64'(e.sop));
        chk("out_eop", 64'(out_eop), 64'(e.eop));
        chk("out_chan", 64'(out_chan), 64'(e.chan));
      end
    end
  endtask

  task automatic push_frame(input int unsigned len, input logic [15:0] chan,
                            input logic rnd, input logic [63:0] base);
    exp_t e;
    logic [63:0] d;
    logic [31:0] upper;
    logic [15:0] l16;
    upper = rnd ? $urandom : 32'd0;
    l16 = 16'(len);
    txq.push_back({upper, chan, l16});
    for (int unsigned i = 0; i < len; i++) begin
      d = rnd ? {$urandom, $urandom} : base + 64'(i);
      txq.push_back(d);
      e.data = d;
      e.sop  = (i == 0);
      e.eop  = (i == len - 1);
      e.chan = chan;
      sb.push_back(e);
    end
    if (len > 0) exp_frames++;
  endtask

  task automatic pump(input int unsigned vld_pct, input int unsigned rdy_pct,
                      output int unsigned cycles);
    logic acc;
    logic v;
    logic r;
    cycles = 0;
    while (txq.size() > 0 && cycles < 20000) begin
      v = ($urandom_range(99) < vld_pct);
      r = ($urandom_range(99) < rdy_pct);
      step(v, txq[0], r, acc);
      cycles++;
      if (acc) void'(txq.pop_front());
    end
    chk("pump_done", 64'(txq.size()), 64'd0);
  endtask

  task automatic drain();
    logic acc;
    int unsigned n;
    n = 0;
    while (sb.size() > 0 && n < 2000) begin
      step(1'b0, '0, 1'b1, acc);
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    step(1'b0, '0, 1'b1, acc);
  endtask

  initial begin
    logic acc;
    int unsigned cyc;

    // Reset asserted mid-cycle: outputs clear immediately
    #2 rst = 1'b1;
    #1;
    chk("rst_in_rdy", 64'(in_rdy), 64'd0);
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_flags", {61'd0, out_sop, out_eop, err_zero_len}, 64'd0);
    chk("rst_out_chan", 64'(out_chan), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_in_rdy_low", 64'(in_rdy), 64'd0);
    @(posedge clk);
    #1;
    chk("rel_in_rdy_high", 64'(in_rdy), 64'd1);

    // Basic frame, fixed header and payload
    push_frame(3, 16'h0005, 1'b0, 64'hA0);
    chk("basic_hdr_word", txq[0], 64'h0000_0000_0005_0003);
    step(1'b1, txq[0], 1'b1, acc); chk("basic_hdr_acc", 64'(acc), 64'd1); void'(txq.pop_front());
    step(1'b1, txq[0], 1'b1, acc); chk("basic_a0_acc", 64'(acc), 64'd1); void'(txq.pop_front());
    chk("basic_hdr_no_out", 64'(out_vld), 64'd0);
    step(1'b1, txq[0], 1'b1, acc); void'(txq.pop_front());
    chk("basic_lat_vld", 64'(out_vld), 64'd1);
    chk("basic_lat_data", out_data, 64'hA0);
    step(1'b1, txq[0], 1'b1, acc); void'(txq.pop_front());
    drain();
    chk("basic_frame_cnt", 64'(frame_cnt), 64'(exp_frames));

    // Backpressure: header plus four words fill the FIFO, then in_rdy drops
    push_frame(10, 16'h00B2, 1'b1, '0);
    for (int unsigned i = 0; i < 5; i++) begin
      step(1'b1, txq[0], 1'b0, acc);
      chk("bp_fill_acc", 64'(acc), 64'd1);
      if (acc) void'(txq.pop_front());
    end
    step(1'b1, txq[0], 1'b0, acc);
    chk("bp_in_rdy_low", 64'(in_rdy), 64'd0);
    chk("bp_out_vld", 64'(out_vld), 64'd1);
    pump(100, 100, cyc);
    drain();
    chk("bp_frame_cnt", 64'(frame_cnt), 64'(exp_frames));

    // Zero-length header
    push_frame(0, 16'h0007, 1'b1, '0);
    step(1'b1, txq[0], 1'b1, acc); chk("zl_hdr_acc", 64'(acc), 64'd1); void'(txq.pop_front());
    step(1'b0, '0, 1'b1, acc);
    chk("zl_err_pulse", 64'(err_zero_len), 64'd1);
    chk("zl_no_out", 64'(out_vld), 64'd0);
    chk("zl_in_rdy", 64'(in_rdy), 64'd1);
    step(1'b0, '0, 1'b1, acc);
    chk("zl_err_clear", 64'(err_zero_len), 64'd0);

    // Single-word frame
    push_frame(1, 16'h1234, 1'b0, 64'hBEEF);
    step(1'b1, txq[0], 1'b1, acc); void'(txq.pop_front());
    step(1'b1, txq[0], 1'b1, acc); chk("sw_acc", 64'(acc), 64'd1); void'(txq.pop_front());
    step(1'b0, '0, 1'b1, acc);
    chk("sw_sop_eop", {62'd0, out_sop, out_eop}, 64'd3);
    drain();
    chk("sw_frame_cnt", 64'(frame_cnt), 64'(exp_frames));

    // Back-to-back frames at full rate: 2 headers + 6 words in 8 cycles
    push_frame(3, 16'h0101, 1'b1, '0);
    push_frame(3, 16'h0202, 1'b1, '0);
    pump(100, 100, cyc);
    chk("b2b_cycles", 64'(cyc), 64'd8);
    drain();

    // 50 random frames with random gaps and random consumer readiness
    for (int unsigned f = 0; f < 50; f++)
      push_frame($urandom_range(20, 1), 16'($urandom), 1'b1, '0);
    pump(70, 60, cyc);
    drain();
    chk("rand_frame_cnt", 64'(frame_cnt), 64'(exp_frames));

    // Counter wrap
    @(negedge clk);
    force dut.r_frame_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_frame_cnt;
    chk("wrap_preset", 64'(frame_cnt), 64'hFFFF_FFFF);
    push_frame(2, 16'h0F0F, 1'b1, '0);
    pump(100, 100, cyc);
    drain();
    chk("wrap_zero", 64'(frame_cnt), 64'd0);

    // Mid-frame reset after 3 payload words
    push_frame(8, 16'h0042, 1'b1, '0);
    for (int unsigned i = 0; i < 4; i++) begin
      step(1'b1, txq[0], 1'b0, acc);
      if (acc) void'(txq.pop_front());
    end
    chk("mid_partial_vld", 64'(out_vld), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_vld", 64'(out_vld), 64'd0);
    chk("mid_rst_in_rdy", 64'(in_rdy), 64'd0);
    chk("mid_rst_frame_cnt", 64'(frame_cnt), 64'd0);
    txq.delete();
    sb.delete();
    exp_frames = 0;
    @(negedge clk);
    rst = 1'b0;
    push_frame(2, 16'h0077, 1'b1, '0);
    pump(100, 100, cyc);
    drain();
    chk("mid_next_frame_cnt", 64'(frame_cnt), 64'(exp_frames));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
